// File: rtl/mem_stage.sv
// mem_stage -- pipeline MEM stage between EX and writeback.
//
// An EX result that is not a memory op retires one cycle after it is presented.
// A word-aligned load or store issues a single memory request. The stage then
// waits in WAIT until mem_ack_i arrives, and the op retires on the edge after
// the ack. A misaligned load or store issues no request. It retires at once
// with no register write and a one-cycle err_o pulse.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES
// cycles without ack. The abort pulses err_o and retires the op with no
// register write.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   valid_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i,
//   alu_data_i, wdata_i, rd_i
//                           EX result and its control bits
//   stall_o                 combinational; upstream holds its inputs while high
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
//                           registered memory request
//   mem_ack_i, mem_rdata_i  memory completion and load data
//   wb_valid_o, wb_regwrite_o, wb_rd_o, wb_data_o
//                           registered writeback bundle
//   err_o                   one-cycle pulse on a misaligned access or a timeout
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_regwrite_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state;
  logic       rd_regwrite_q;   // RegWrite of the outstanding op; already cleared for stores
  logic       memtoreg_q;
  logic [4:0] rd_q;

  logic is_mem, misaligned, done;
  assign is_mem     = MemRead_i | MemWrite_i;
  assign misaligned = alu_data_i[1:0] != 2'b00;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  // Fires in the last allowed ack-less WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state == WAIT) && !mem_ack_i
                       && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done        = mem_ack_i | timeout_hit;
`else
  assign done        = mem_ack_i;
`endif

  // WAIT releases stall in the cycle that retires the op. An ack and a timeout
  // both count. Releasing on a timeout stops the held op from being reissued.
  always_comb begin
    stall_o = 1'b0;
    if (state == IDLE) stall_o = valid_i && is_mem && !misaligned;
    else               stall_o = !done;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      wb_rd_o       <= '0;
      wb_data_o     <= '0;
      err_o         <= 1'b0;
      rd_regwrite_q <= 1'b0;
      memtoreg_q    <= 1'b0;
      rd_q          <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      err_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              wb_valid_o    <= 1'b1;
              wb_regwrite_o <= RegWrite_i;
              wb_rd_o       <= rd_i;
              wb_data_o     <= alu_data_i;
            end else if (misaligned) begin
              err_o      <= 1'b1;
              wb_valid_o <= 1'b1;
              wb_rd_o    <= rd_i;
              wb_data_o  <= alu_data_i;
            end else begin
              state         <= WAIT;
              mem_req_o     <= 1'b1;
              mem_we_o      <= MemWrite_i;  // read+write together is treated as a store
              mem_addr_o    <= alu_data_i;
              mem_wdata_o   <= wdata_i;
              rd_q          <= rd_i;
              rd_regwrite_q <= RegWrite_i & ~MemWrite_i;
              memtoreg_q    <= MemtoReg_i & ~MemWrite_i;
`ifdef MEM_TIMEOUT_EN
              wait_cnt      <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (mem_ack_i) begin
            state         <= IDLE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            wb_valid_o    <= 1'b1;
            wb_regwrite_o <= rd_regwrite_q;
            wb_rd_o       <= rd_q;
            wb_data_o     <= memtoreg_q ? mem_rdata_i : mem_addr_o;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            err_o      <= 1'b1;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_q;
            wb_data_o  <= mem_addr_o;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-memory op, load, store, read+write op,
// misaligned access, ack while idle, reset during WAIT, and the WAIT timeout
// (or its absence in the default build).
module tb_mem_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 1'b0, mrd = 1'b0, mwr = 1'b0, rgw = 1'b0, m2r = 1'b0;
  logic [31:0] alu = '0, wdata = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic        ack = 1'b0;
  logic        stall, req, we, wbv, wbrw, err;
  logic [31:0] addr, mwdata, wbd;
  logic [4:0]  wbrd;

  int n_cmp = 0, n_bad = 0;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .MemRead_i(mrd), .MemWrite_i(mwr), .RegWrite_i(rgw), .MemtoReg_i(m2r),
    .alu_data_i(alu), .wdata_i(wdata), .rd_i(rd),
    .stall_o(stall), .mem_req_o(req), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(mwdata),
    .mem_ack_i(ack), .mem_rdata_i(rdata),
    .wb_valid_o(wbv), .wb_regwrite_o(wbrw), .wb_rd_o(wbrd), .wb_data_o(wbd),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic v, input logic r, input logic w, input logic rw,
                        input logic mr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] d);
    valid = v; mrd = r; mwr = w; rgw = rw; m2r = mr; alu = a; wdata = wd; rd = d;
  endtask

  initial begin
    int n;
    int bad;
    // reset state
    #12;
    chk("rst_req", req, 0);       chk("rst_wbv", wbv, 0);
    chk("rst_err", err, 0);       chk("rst_wbd", wbd, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1; rst = 1'b0;

    // add: non-memory op retires after one cycle
    set_op(1, 0, 0, 1, 0, 32'h10, 0, 5'd3);
    #1 chk("add_stall", stall, 0);
    tick();
    chk("add_wbv", wbv, 1);       chk("add_wbd", wbd, 32'h10);
    chk("add_wbrd", wbrd, 3);     chk("add_wbrw", wbrw, 1);
    chk("add_req", req, 0);
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("idle_wbv", wbv, 0);      chk("idle_wbrw", wbrw, 0);

    // lw 0x40: ack in the third request cycle
    set_op(1, 1, 0, 1, 1, 32'h40, 0, 5'd5);
    #1 chk("lw_stall_issue", stall, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ack = 1'b1; rdata = 32'hDEADBEEF; end
      #1;
      chk($sformatf("lw_req_%0d", i), req, 1);
      chk($sformatf("lw_addr_%0d", i), addr, 32'h40);
      chk($sformatf("lw_we_%0d", i), we, 0);
      chk($sformatf("lw_stall_%0d", i), stall, (i != 2));
      chk($sformatf("lw_wbv_%0d", i), wbv, 0);
      tick();
    end
    ack = 1'b0;
    chk("lw_ret_wbv", wbv, 1);    chk("lw_ret_wbd", wbd, 32'hDEADBEEF);
    chk("lw_ret_wbrw", wbrw, 1);  chk("lw_ret_wbrd", wbrd, 5);
    chk("lw_ret_req", req, 0);

    // sw 0x44 presented right after the load retires; ack after one cycle
    set_op(1, 0, 1, 0, 0, 32'h44, 32'h12345678, 5'd7);
    #1 chk("sw_stall_issue", stall, 1);
    tick();
    chk("sw_req", req, 1);        chk("sw_we", we, 1);
    chk("sw_addr", addr, 32'h44); chk("sw_wdata", mwdata, 32'h12345678);
    chk("sw_wbv_wait", wbv, 0);
    ack = 1'b1;
    #1 chk("sw_stall_ack", stall, 0);
    tick();
    ack = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sw_ret_wbv", wbv, 1);    chk("sw_ret_wbrw", wbrw, 0);
    chk("sw_ret_req", req, 0);
    tick();
    chk("sw_after_wbv", wbv, 0);

    // MemRead and MemWrite both high behave as a store
    set_op(1, 1, 1, 1, 1, 32'h48, 32'hA5A5A5A5, 5'd9);
    tick();
    chk("rw_we", we, 1);          chk("rw_wdata", mwdata, 32'hA5A5A5A5);
    ack = 1'b1; rdata = 32'h0BADF00D;
    tick();
    ack = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rw_ret_wbv", wbv, 1);    chk("rw_ret_wbrw", wbrw, 0);

    // misaligned lw 0x42
    set_op(1, 1, 0, 1, 1, 32'h42, 0, 5'd4);
    #1 chk("mis_stall", stall, 0);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mis_req", req, 0);       chk("mis_err", err, 1);
    chk("mis_wbv", wbv, 1);       chk("mis_wbrw", wbrw, 0);
    tick();
    chk("mis_err_clr", err, 0);   chk("mis_wbv_clr", wbv, 0);

    // ack while idle is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_wbv", wbv, 0);  chk("idle_ack_req", req, 0);
    chk("idle_ack_err", err, 0);

    // reset two cycles into WAIT, then a late ack
    set_op(1, 1, 0, 1, 1, 32'h80, 0, 5'd6);
    tick();
    chk("rstw_req", req, 1);
    tick();
    #2 rst = 1'b1;
    #1 chk("rstw_req_now", req, 0);
    chk("rstw_wbv", wbv, 0);
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    ack = 1'b1; rdata = 32'hFFFFFFFF;
    tick();
    ack = 1'b0;
    chk("late_ack_wbv", wbv, 0);  chk("late_ack_req", req, 0);
    chk("late_ack_err", err, 0);

    // load with no ack: timeout after 16 WAIT cycles, or an indefinite WAIT
    set_op(1, 1, 0, 1, 1, 32'h100, 0, 5'd8);
    tick();
`ifdef MEM_TIMEOUT_EN
    n = 0;
    while (req && n < 40) begin n++; tick(); end
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_wait_cycles", n, 16);
    chk("to_req", req, 0);        chk("to_err", err, 1);
    chk("to_wbv", wbv, 1);        chk("to_wbrw", wbrw, 0);
    tick();
    chk("to_err_clr", err, 0);    chk("to_idle_req", req, 0);
`else
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (!req || !stall || wbv) bad++;
      tick();
    end
    chk("nto_hold_cycles_bad", bad, 0);
    ack = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    ack = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nto_ret_wbv", wbv, 1);   chk("nto_ret_wbd", wbd, 32'hCAFEF00D);
    chk("nto_ret_req", req, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of WAIT cycles without ack before abort (used only under MEM_TIMEOUT_EN).
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 valid_i  input  1  upstream EX result is valid this cycle.
REQ-005 MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  input  1 each  control bits for the EX result.
REQ-006 alu_data_i  input  32  ALU result: memory address for lw/sw, writeback value otherwise.
REQ-007 wdata_i  input  32  store data; rd_i  input  5  destination register.
REQ-008 stall_o  output  1  combinational; upstream holds all inputs while high.
REQ-009 mem_req_o, mem_we_o  output  1  registered memory request and write enable.
REQ-010 mem_addr_o, mem_wdata_o  output  32  registered address and store data.
REQ-011 mem_ack_i  input  1; mem_rdata_i  input  32  memory completion and load data, valid in the ack cycle.
REQ-012 wb_valid_o, wb_regwrite_o  output  1; wb_rd_o  output  5; wb_data_o  output  32  registered writeback bundle.
REQ-013 err_o  output  1  registered one-cycle pulse on misaligned access or timeout.

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT.
REQ-015 Non-memory op (valid_i=1, MemRead_i=MemWrite_i=0) in IDLE: wb_* SHALL load alu_data_i, rd_i, RegWrite_i on the next edge with wb_valid_o=1 (latency 1), with stall_o=0.
REQ-016 Memory op in IDLE with alu_data_i[1:0]=0: stall_o=1; next edge SHALL go to WAIT with mem_req_o=1, mem_we_o=MemWrite_i, mem_addr_o=alu_data_i, mem_wdata_o=wdata_i, and rd/RegWrite/MemtoReg latched internally.
REQ-017 In WAIT, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL stay stable until the ack cycle, and stall_o SHALL equal NOT mem_ack_i.
REQ-018 Ack in WAIT: the next edge SHALL return to IDLE, drop mem_req_o, and pulse wb_valid_o=1.
REQ-019 On that ack, wb_data_o SHALL be mem_rdata_i if MemtoReg is latched, else the latched address.
REQ-020 On that ack, wb_regwrite_o SHALL equal the latched RegWrite; a store SHALL never write back.
REQ-021 wb_valid_o SHALL be 0 in every cycle without a retirement, including all WAIT cycles and cycles where valid_i=0.
REQ-022 When wb_valid_o=0, wb_regwrite_o SHALL be 0.
REQ-023 A misaligned memory op (alu_data_i[1:0]!=0) in IDLE SHALL issue no request, keep stall_o=0, and set err_o=1 for one cycle on the next edge.
REQ-024 The same misaligned op SHALL retire with wb_valid_o=1 and wb_regwrite_o=0.
REQ-025 mem_ack_i asserted while in IDLE SHALL be ignored.
REQ-026 MemRead_i and MemWrite_i both high SHALL be treated as a store.
REQ-027 Back-to-back ops: an op presented in the ack cycle SHALL be accepted on the edge following the ack retirement, with no op lost or duplicated.

Reset
REQ-028 While rst_i=1, state SHALL be IDLE and every registered output (mem_*, wb_*, err_o) and the timeout counter SHALL be 0, independent of clk_i.
REQ-029 A reset during WAIT SHALL abandon the access: mem_req_o=0 immediately and no retirement.
REQ-030 An ack arriving after reset deassertion for the abandoned access SHALL be ignored.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-032 Under MEM_TIMEOUT_EN, TIMEOUT_CYCLES consecutive WAIT cycles without ack SHALL return to IDLE, drop mem_req_o, pulse err_o, and retire with wb_valid_o=1, wb_regwrite_o=0.
REQ-033 Without MEM_TIMEOUT_EN, WAIT SHALL last indefinitely until ack, and no counter logic SHALL exist.

Verification
REQ-034 add: valid_i=1, alu_data_i=0x0000_0010, rd_i=3, RegWrite_i=1 -> next cycle wb_valid_o=1, wb_data_o=0x10, wb_rd_o=3; stall_o never high.
REQ-035 lw: address 0x40, ack 3 cycles after request with mem_rdata_i=0xDEAD_BEEF -> mem_req_o high 3 cycles with mem_addr_o=0x40 stable; stall_o high until the ack cycle; then wb_data_o=0xDEAD_BEEF, wb_regwrite_o=1.
REQ-036 sw: address 0x44, wdata_i=0x1234_5678, ack 1 cycle -> mem_we_o=1, mem_wdata_o=0x1234_5678; retire with wb_regwrite_o=0.
REQ-037 lw at address 0x42 -> no mem_req_o, err_o pulse 1 cycle, wb_valid_o=1 with wb_regwrite_o=0.
REQ-038 rst_i asserted 2 cycles into a WAIT, then a late ack -> mem_req_o=0 at once, no wb_valid_o, ack ignored.
REQ-039 With MEM_TIMEOUT_EN and no ack -> after 16 WAIT cycles err_o pulses, mem_req_o falls, FSM returns to IDLE; without the macro -> mem_req_o stays high for 100+ cycles.
